// File: rtl/rv_pkg.sv
// Shared RV32I definitions: opcodes, control FSM states and the datapath control bundle.
// Used by the main control FSM, its output decoder and the bench.
package rv_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_SB    = 7'b1100011;
  localparam logic [6:0] OP_UJ    = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_U     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_FENCE = 7'b0001111;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} ctrl_state_t;

  typedef enum logic [1:0] {PcPlus4 = 2'd0, PcAlu = 2'd1, PcReset = 2'd2} pc_src_t;
  typedef enum logic [1:0] {AluARs1 = 2'd0, AluAOldPc = 2'd1, AluAZero = 2'd2} alu_a_t;
  typedef enum logic [1:0] {WbAlu = 2'd0, WbMem = 2'd1, WbPc4 = 2'd2} wb_sel_t;

  typedef struct packed {
    logic    mem_req;
    logic    mem_we;
    logic    mem_sel_instr;
    logic    ir_we;
    logic    pc_we;
    pc_src_t pc_src;
    alu_a_t  alu_src_a;
    logic    alu_src_b;
    logic    rf_we;
    wb_sel_t wb_sel;
  } ctrl_out_t;

  // Opcodes that proceed from DECODE into EXEC.
  function automatic logic is_exec_op(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_S, OP_SB, OP_UJ, OP_JALR, OP_U, OP_AUIPC: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_outdec.sv
// Combinational decode of control state, opcode and handshake inputs into the
// datapath enable/select bundle.
module ctrl_outdec
  import rv_pkg::*;
(
  input  ctrl_state_t i_state,
  input  logic [6:0]  i_opcode,
  input  logic        i_mem_ready,
  input  logic        i_branch_taken,
  output ctrl_out_t   o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      FETCH: begin
        o_ctrl.mem_req       = 1'b1;
        o_ctrl.mem_sel_instr = 1'b1;
        if (i_mem_ready) begin
          o_ctrl.ir_we  = 1'b1;
          o_ctrl.pc_we  = 1'b1;
          o_ctrl.pc_src = PcPlus4;
        end
      end
      EXEC: begin
        case (i_opcode)
          OP_R: begin
            o_ctrl.alu_src_a = AluARs1;
            o_ctrl.alu_src_b = 1'b0;
          end
          OP_I, OP_LOAD, OP_S, OP_JALR: begin
            o_ctrl.alu_src_a = AluARs1;
            o_ctrl.alu_src_b = 1'b1;
          end
          OP_SB: begin
            o_ctrl.alu_src_a = AluAOldPc;
            o_ctrl.alu_src_b = 1'b1;
            o_ctrl.pc_we     = i_branch_taken;
            o_ctrl.pc_src    = PcAlu;
          end
          OP_UJ, OP_AUIPC: begin
            o_ctrl.alu_src_a = AluAOldPc;
            o_ctrl.alu_src_b = 1'b1;
          end
          OP_U: begin
            o_ctrl.alu_src_a = AluAZero;
            o_ctrl.alu_src_b = 1'b1;
          end
          default: ;
        endcase
      end
      MEM: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.mem_we  = (i_opcode == OP_S);
      end
      WB: begin
        o_ctrl.rf_we = 1'b1;
        case (i_opcode)
          OP_LOAD: o_ctrl.wb_sel = WbMem;
          OP_UJ, OP_JALR: begin
            // Link value goes to rd while the PC takes the registered jump target.
            o_ctrl.wb_sel = WbPc4;
            o_ctrl.pc_we  = 1'b1;
            o_ctrl.pc_src = PcAlu;
          end
          default: o_ctrl.wb_sel = WbAlu;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences FETCH/DECODE/EXEC/MEM/WB
// and handshakes the unified memory port.
module multicycle_ctrl
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned XLEN     = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_sel_instr,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic [1:0] alu_src_a,
  output logic       alu_src_b,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       illegal_instr,
  output logic [2:0] state_o
);

  if (XLEN != 32 || RESET_PC[1:0] != 2'b00) begin : g_cfg_err
    $error("multicycle_ctrl: unsupported XLEN or misaligned RESET_PC");
  end

  ctrl_state_t r_state;
  ctrl_state_t w_state_next;
  logic        r_illegal;
  ctrl_out_t   w_dec;
  ctrl_out_t   w_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next == TRAP) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH: if (mem_ready) w_state_next = DECODE;
      DECODE: begin
        if (opcode == OP_FENCE)     w_state_next = FETCH;
        else if (is_exec_op(opcode)) w_state_next = EXEC;
        else                         w_state_next = TRAP;
      end
      EXEC: begin
        if (opcode == OP_SB)                         w_state_next = FETCH;
        else if (opcode == OP_LOAD || opcode == OP_S) w_state_next = MEM;
        else                                          w_state_next = WB;
      end
      MEM: begin
        if (mem_ready) begin
          if (opcode == OP_LOAD) w_state_next = WB;
          else                   w_state_next = FETCH;
        end
      end
      WB:      w_state_next = FETCH;
      TRAP:    w_state_next = TRAP;
      default: w_state_next = FETCH;
    endcase
  end

  ctrl_outdec u_outdec (
    .i_state        (r_state),
    .i_opcode       (opcode),
    .i_mem_ready    (mem_ready),
    .i_branch_taken (branch_taken),
    .o_ctrl         (w_dec)
  );

  // Reset overrides the decode so the PC loads RESET_PC and any pending request drops.
  always_comb begin
    w_out = w_dec;
    if (rst) begin
      w_out        = '0;
      w_out.pc_we  = 1'b1;
      w_out.pc_src = PcReset;
    end
  end

  assign mem_req       = w_out.mem_req;
  assign mem_we        = w_out.mem_we;
  assign mem_sel_instr = w_out.mem_sel_instr;
  assign ir_we         = w_out.ir_we;
  assign pc_we         = w_out.pc_we;
  assign pc_src        = w_out.pc_src;
  assign alu_src_a     = w_out.alu_src_a;
  assign alu_src_b     = w_out.alu_src_b;
  assign rf_we         = w_out.rf_we;
  assign wb_sel        = w_out.wb_sel;
  assign illegal_instr = r_illegal & ~rst;
  assign state_o       = rst ? FETCH : r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected output vectors are queued
// as stimulus is driven and compared on the following falling edge.
module tb_multicycle_ctrl;
  import rv_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       branch_taken;
  logic       mem_req, mem_we, mem_sel_instr, ir_we, pc_we, alu_src_b, rf_we, illegal_instr;
  logic [1:0] pc_src, alu_src_a, wb_sel;
  logic [2:0] state_o;

  multicycle_ctrl #(
    .RESET_PC (32'h0000_0000),
    .XLEN     (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .branch_taken  (branch_taken),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_sel_instr (mem_sel_instr),
    .ir_we         (ir_we),
    .pc_we         (pc_we),
    .pc_src        (pc_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .rf_we         (rf_we),
    .wb_sel        (wb_sel),
    .illegal_instr (illegal_instr),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [16:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  wire [16:0] w_dut_vec = {state_o, mem_req, mem_we, mem_sel_instr, ir_we, pc_we, pc_src,
                           alu_src_a, alu_src_b, rf_we, wb_sel, illegal_instr};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Field order: state, req, we, sel_instr, ir_we, pc_we, pc_src, alu_a, alu_b, rf_we, wb, ill
  function automatic logic [16:0] mk(input logic [2:0] st, input logic req, input logic we,
                                     input logic sel, input logic irwe, input logic pcwe,
                                     input logic [1:0] psrc, input logic [1:0] a,
                                     input logic b, input logic rfwe, input logic [1:0] wb,
                                     input logic ill);
    return {st, req, we, sel, irwe, pcwe, psrc, a, b, rfwe, wb, ill};
  endfunction

  localparam logic [16:0] RstVec = {3'd0, 5'b00001, 2'd2, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0};

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq(e.tag, {15'd0, w_dut_vec}, {15'd0, e.vec});
    end
  end

  task automatic cyc(input string tag, input logic r, input logic rdy, input logic [6:0] op,
                     input logic bt, input logic [16:0] e);
    exp_t x;
    rst          = r;
    mem_ready    = rdy;
    opcode       = op;
    branch_taken = bt;
    x.tag = tag;
    x.vec = e;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_wait(input string tag, input int n);
    for (int i = 0; i < n; i++)
      cyc({tag, "_fwait"}, 1'b0, 1'b0, 7'($urandom), 1'($urandom),
          mk(FETCH, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0));
  endtask

  task automatic run_instr(input string tag, input logic [6:0] op, input int fw, input int mw,
                           input logic bt);
    logic [1:0] a;
    logic       b;
    logic       jump;
    logic [1:0] wb;
    fetch_wait(tag, fw);
    cyc({tag, "_fetch"}, 1'b0, 1'b1, 7'($urandom), bt,
        mk(FETCH, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0));
    cyc({tag, "_dec"}, 1'b0, 1'b1, op, bt,
        mk(DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0));
    if (op == OP_FENCE) return;
    case (op)
      OP_R:                    begin a = 2'd0; b = 1'b0; end
      OP_SB, OP_UJ, OP_AUIPC:  begin a = 2'd1; b = 1'b1; end
      OP_U:                    begin a = 2'd2; b = 1'b1; end
      default:                 begin a = 2'd0; b = 1'b1; end
    endcase
    if (op == OP_SB)
      cyc({tag, "_exec"}, 1'b0, 1'b1, op, bt,
          mk(EXEC, 1'b0, 1'b0, 1'b0, 1'b0, bt, 2'd1, a, b, 1'b0, 2'd0, 1'b0));
    else
      cyc({tag, "_exec"}, 1'b0, 1'b1, op, bt,
          mk(EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, a, b, 1'b0, 2'd0, 1'b0));
    if (op == OP_SB) return;
    if (op == OP_LOAD || op == OP_S) begin
      for (int i = 0; i <= mw; i++)
        cyc({tag, "_mem"}, 1'b0, (i == mw), op, bt,
            mk(MEM, 1'b1, (op == OP_S), 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0));
      if (op == OP_S) return;
    end
    jump = (op == OP_UJ || op == OP_JALR);
    wb   = (op == OP_LOAD) ? 2'd1 : (jump ? 2'd2 : 2'd0);
    cyc({tag, "_wb"}, 1'b0, 1'b1, op, bt,
        mk(WB, 1'b0, 1'b0, 1'b0, 1'b0, jump, jump ? 2'd1 : 2'd0, 2'd0, 1'b0, 1'b1, wb, 1'b0));
  endtask

  initial begin
    rst          = 1'b1;
    mem_ready    = 1'b1;
    opcode       = 7'd0;
    branch_taken = 1'b0;
    @(posedge clk);
    #1;

    repeat (3) cyc("reset", 1'b1, 1'b1, OP_R, 1'b0, RstVec);

    run_instr("addi",   OP_I,     0, 0, 1'b1);
    run_instr("lw",     OP_LOAD,  2, 3, 1'b0);
    run_instr("beq_t",  OP_SB,    0, 0, 1'b1);
    run_instr("beq_nt", OP_SB,    0, 0, 1'b0);
    run_instr("sw",     OP_S,     0, 1, 1'b0);
    run_instr("jal",    OP_UJ,    0, 0, 1'b0);
    run_instr("jalr",   OP_JALR,  1, 0, 1'b1);
    run_instr("add",    OP_R,     0, 0, 1'b0);
    run_instr("lui",    OP_U,     0, 0, 1'b0);
    run_instr("auipc",  OP_AUIPC, 0, 0, 1'b1);
    run_instr("fence",  OP_FENCE, 1, 0, 1'b0);
    run_instr("sw0",    OP_S,     0, 0, 1'b1);

    // Illegal opcode: trap sticks with no requests even while memory signals ready.
    cyc("ill_fetch", 1'b0, 1'b1, 7'h7F, 1'b0,
        mk(FETCH, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0));
    cyc("ill_dec", 1'b0, 1'b1, 7'h7F, 1'b0,
        mk(DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0));
    repeat (4)
      cyc("ill_trap", 1'b0, 1'b1, 7'h7F, 1'b1,
          mk(TRAP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1));
    cyc("trap_rst", 1'b1, 1'b1, 7'h7F, 1'b0, RstVec);

    // Reset in the middle of a stalled fetch; the ack during reset must be ignored.
    fetch_wait("mid", 2);
    cyc("mid_rst", 1'b1, 1'b1, OP_I, 1'b0, RstVec);
    run_instr("addi2", OP_I, 0, 0, 1'b0);
    run_instr("lw2",   OP_LOAD, 0, 0, 1'b1);

    @(negedge clk);
    check_eq("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
